// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, reset PC and prefetch FSM state encoding.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  typedef enum logic {BOOT, RUN} fetch_state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: register-based FIFO with synchronous flush and occupancy count.
module prefetch_fifo #(
  parameter int W = 32,
  parameter int D = 4,
  localparam int AW = $clog2(D),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [D];
  logic [W-1:0] mem_d [D];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  // storage is reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetch with credit-limited
// in-flight requests, in-order response buffering and redirect flush.
module fetch_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic            IMEM_REQ_V,
  output logic [XLEN-1:0] IMEM_REQ_ADDR,
  input  logic            IMEM_REQ_RDY,
  input  logic            IMEM_RSP_V,
  input  logic [ILEN-1:0] IMEM_RSP_DATA,
  input  logic            REDIRECT_V,
  input  logic [XLEN-1:0] REDIRECT_ADDR,
  output logic            FE_V,
  output logic [ILEN-1:0] FE_IR,
  output logic [XLEN-1:0] FE_PC,
  output logic [XLEN-1:0] FE_NPC,
  input  logic            FE_RDY
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  fetch_state_e state_q, state_d;
  logic run;
  logic [XLEN-1:0] pc_q, pc_d, tag;
  logic [CW-1:0] disc_q, disc_d, count, outs;
  logic [XLEN+ILEN-1:0] head;
  logic req_fire, rsp_fire, push, pop;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= BOOT;
    else state_q <= state_d;
  end
  always_comb state_d = (state_q == BOOT) ? RUN : state_q;
  always_comb run = (state_q == RUN);
  // queued words plus outstanding requests never exceed DEPTH, so pushes never overflow
  assign IMEM_REQ_V = run && (SW'(count) + SW'(outs) < SW'(DEPTH)) && !REDIRECT_V;
  assign IMEM_REQ_ADDR = pc_q;
  assign req_fire = IMEM_REQ_V && IMEM_REQ_RDY;
  assign rsp_fire = IMEM_RSP_V && (outs != '0);
  assign push = rsp_fire && (disc_q == '0) && !REDIRECT_V;
  assign pop = FE_V && FE_RDY && !REDIRECT_V;
  always_comb begin
    pc_d = REDIRECT_V ? (REDIRECT_ADDR & ~XLEN'(3)) : pc_q + (req_fire ? XLEN'(INSN_BYTES) : '0);
    disc_d = REDIRECT_V ? disc_q + outs - CW'(rsp_fire) : disc_q - CW'(rsp_fire && (disc_q != '0));
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= RESET_PC;
      disc_q <= '0;
    end else begin
      pc_q <= pc_d;
      disc_q <= disc_d;
    end
  end
  // tag FIFO occupancy is the outstanding-request count; stale tags drain with their responses
  prefetch_fifo #(.W(XLEN), .D(DEPTH)) u_tag (
    .clk(CLK), .rst_n(RESET), .flush(1'b0), .push(req_fire), .din(pc_q),
    .pop(rsp_fire), .dout(tag), .count(outs)
  );
  prefetch_fifo #(.W(XLEN + ILEN), .D(DEPTH)) u_queue (
    .clk(CLK), .rst_n(RESET), .flush(REDIRECT_V), .push(push), .din({tag, IMEM_RSP_DATA}),
    .pop(pop), .dout(head), .count(count)
  );
  assign FE_V = (count != '0);
  assign FE_PC = head[XLEN+ILEN-1:ILEN];
  assign FE_IR = head[ILEN-1:0];
  assign FE_NPC = FE_V ? FE_PC + XLEN'(INSN_BYTES) : '0;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed checks of fetch_prefetch_queue against an
// in-order fixed-latency memory that returns the request address as the word.
module tb_fetch_prefetch_queue;
  logic clk = 1'b0;
  logic rst_n, req_v, req_rdy, rsp_v, redir, fe_v, fe_rdy;
  logic [63:0] req_addr, raddr, fe_pc, fe_npc;
  logic [31:0] rsp_data, fe_ir;
  int total = 0, bad = 0, cyc = 0, lat = 1;
  typedef struct {logic [63:0] a; int due;} mreq_t;
  mreq_t mq[$];
  logic [63:0] reqlog[$];

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .CLK(clk), .RESET(rst_n), .IMEM_REQ_V(req_v), .IMEM_REQ_ADDR(req_addr),
    .IMEM_REQ_RDY(req_rdy), .IMEM_RSP_V(rsp_v), .IMEM_RSP_DATA(rsp_data),
    .REDIRECT_V(redir), .REDIRECT_ADDR(raddr), .FE_V(fe_v), .FE_IR(fe_ir),
    .FE_PC(fe_pc), .FE_NPC(fe_npc), .FE_RDY(fe_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle: present any due response, log a firing request, advance to the next negedge
  task automatic tick();
    mreq_t m;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_v = 1'b1;
      rsp_data = mq[0].a[31:0];
      mq.delete(0);
    end else begin
      rsp_v = 1'b0;
      rsp_data = '0;
    end
    #1;
    if (req_v && req_rdy) begin
      m.a = req_addr;
      m.due = cyc + lat;
      mq.push_back(m);
      reqlog.push_back(req_addr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redir = 1'b0;
    mq.delete();
    reqlog.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_rdy = 1'b1; fe_rdy = 1'b1; redir = 1'b0; raddr = '0;
    rsp_v = 1'b0; rsp_data = '0; lat = 1;
    tick();
    tick();
    chk("rst_req_v", req_v, 0);
    chk("rst_req_addr", req_addr, 64'h0);
    chk("rst_fe_v", fe_v, 0);
    chk("rst_fe_ir", fe_ir, 0);
    chk("rst_fe_pc", fe_pc, 0);
    chk("rst_fe_npc", fe_npc, 0);
    rst_n = 1'b1;
    #1 chk("boot_no_req", req_v, 0);
    tick();
    chk("first_req_v", req_v, 1);
    chk("first_req_addr", req_addr, 64'h0);
    tick();
    chk("fe_v_c2", fe_v, 0);
    tick();
    chk("fe_v_c3", fe_v, 1);
    chk("fe_pc_c3", fe_pc, 64'h0);
    chk("fe_ir_c3", fe_ir, 32'h0);
    chk("fe_npc_c3", fe_npc, 64'h4);
    tick();
    chk("fe_pc_c4", fe_pc, 64'h4);
    chk("fe_ir_c4", fe_ir, 32'h4);
    chk("fe_npc_c4", fe_npc, 64'h8);
    chk("seq_n", reqlog.size(), 3);
    chk("seq_1", reqlog[1], 64'h4);
    chk("seq_2", reqlog[2], 64'h8);

    fe_rdy = 1'b0; lat = 1;
    do_reset();
    repeat (10) tick();
    chk("full_nreq", reqlog.size(), 4);
    chk("full_last", reqlog[3], 64'hC);
    chk("full_req_v", req_v, 0);
    chk("full_fe_v", fe_v, 1);
    chk("full_fe_pc", fe_pc, 64'h0);
    fe_rdy = 1'b1;
    tick();
    fe_rdy = 1'b0;
    chk("pop1_fe_pc", fe_pc, 64'h4);
    repeat (6) tick();
    chk("pop1_nreq", reqlog.size(), 5);
    chk("pop1_addr", reqlog[4], 64'h10);
    chk("pop1_req_v", req_v, 0);

    lat = 4; fe_rdy = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("redir_outs", reqlog.size(), 3);
    redir = 1'b1; raddr = 64'h1002;
    #1 chk("redir_no_req", req_v, 0);
    tick();
    redir = 1'b0;
    #1;
    chk("redir_req_v", req_v, 1);
    chk("redir_req_addr", req_addr, 64'h1000);
    for (int i = 0; i < 5; i++) begin
      chk("redir_stale", fe_v, 0);
      tick();
    end
    chk("redir_fe_v", fe_v, 1);
    chk("redir_fe_pc", fe_pc, 64'h1000);
    chk("redir_fe_ir", fe_ir, 32'h1000);
    chk("redir_log", reqlog[3], 64'h1000);

    lat = 2; fe_rdy = 1'b1;
    do_reset();
    repeat (4) tick();
    chk("coll_pre_v", fe_v, 1);
    chk("coll_pre_pc", fe_pc, 64'h0);
    redir = 1'b1; raddr = 64'h2000;
    #1 chk("coll_no_req", req_v, 0);
    tick();
    redir = 1'b0;
    #1;
    chk("coll_nreq", reqlog.size(), 3);
    chk("coll_fe_v", fe_v, 0);
    chk("coll_req_v", req_v, 1);
    chk("coll_req_addr", req_addr, 64'h2000);
    tick();
    chk("coll_c6", fe_v, 0);
    tick();
    chk("coll_c7", fe_v, 0);
    tick();
    chk("coll_c8_v", fe_v, 1);
    chk("coll_c8_pc", fe_pc, 64'h2000);
    chk("coll_c8_ir", fe_ir, 32'h2000);

    lat = 3; fe_rdy = 1'b0;
    do_reset();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_v", req_v, 0);
    chk("mid_rst_addr", req_addr, 64'h0);
    chk("mid_rst_fe_v", fe_v, 0);
    tick();
    rst_n = 1'b1;
    #1 chk("mid_boot", req_v, 0);
    tick();
    chk("mid_req_v", req_v, 1);
    chk("mid_req_addr", req_addr, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_stale", fe_v, 0);
      tick();
    end
    chk("mid_fe_v", fe_v, 1);
    chk("mid_fe_pc", fe_pc, 64'h0);

    lat = 1; fe_rdy = 1'b1;
    do_reset();
    tick();
    redir = 1'b1; raddr = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redir = 1'b0;
    #1;
    chk("wrap_addr0", req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req_v", req_v, 1);
    tick();
    chk("wrap_addr1", req_addr, 64'h0);
    tick();
    chk("wrap_fe_pc", fe_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_fe_ir", fe_ir, 32'hFFFF_FFFC);
    chk("wrap_fe_npc", fe_npc, 64'h0);
    tick();
    chk("wrap2_fe_pc", fe_pc, 64'h0);
    chk("wrap2_fe_npc", fe_npc, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
